// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared state encoding, default parameters and helpers for the
//               FIR stream controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int FIR_N_DEFAULT     = 16;
    localparam int FIR_DEPTH_DEFAULT = 32;
    localparam int FIR_LAT_DEFAULT   = 2;
    localparam int FIR_TAIL_DEFAULT  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } fir_state_t;

    // A zero or oversize request means "use the whole buffer".
    function automatic int calc_len_eff(input int len, input int depth);
        return ((len == 0) || (len > depth)) ? depth : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_ram
// Description : DEPTH x N sample buffer, one write port and one registered
//               read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_ram
    import fir_pkg::*;
#(
    parameter int N     = FIR_N_DEFAULT,
    parameter int DEPTH = FIR_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [N-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [N-1:0]             o_rdata
);

    logic [N-1:0] r_mem [DEPTH];

    // Host write and registered read; read-during-write returns old data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_stream_ctrl
// Description : Streams a host-loaded sample buffer into an external FIR,
//               appends zero tail samples, waits out the filter latency and
//               qualifies the filter results.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int N       = FIR_N_DEFAULT,
    parameter int DEPTH   = FIR_DEPTH_DEFAULT,
    parameter int FIR_LAT = FIR_LAT_DEFAULT,
    parameter int TAIL    = FIR_TAIL_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [N-1:0]             wr_data,
    output logic                     wr_drop,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [$clog2(DEPTH):0]   len,
    output logic                     fir_clr,
    output logic [N-1:0]             fir_din,
    input  logic [N-1:0]             fir_dout,
    output logic                     out_valid,
    output logic [N-1:0]             out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_CNT_MAX = (TAIL > FIR_LAT) ? TAIL : FIR_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_TAIL_LAST = c_CNT_W'(TAIL - 1);
    localparam logic [c_CNT_W-1:0] c_LAT_LAST  = c_CNT_W'(FIR_LAT - 1);

    fir_state_t         r_state;
    fir_state_t         w_state_next;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW-1:0]    r_len_last;   // len_eff - 1, last pointer of a pass
    logic [c_CNT_W-1:0] r_cnt;
    logic [FIR_LAT:0]   r_vpipe;      // bit 0 is in_valid, top bit is out_valid
    logic               r_din_live;   // fir_din carries a buffer sample
    logic [N-1:0]       w_ram_q;
    logic               w_pass_last;
    logic               w_wr_ok;
    logic               w_feed;

    assign w_pass_last = (r_rd_ptr == r_len_last);

    fir_sample_ram #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_CLEAR;
            ST_CLEAR: w_state_next = ST_RUN;
            ST_RUN:   if (stop || (w_pass_last && !loop_en))
                          w_state_next = (TAIL > 0) ? ST_FLUSH : ST_DRAIN;
            ST_FLUSH: if (r_cnt == c_TAIL_LAST) w_state_next = ST_DRAIN;
            ST_DRAIN: if (r_cnt == c_LAT_LAST) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State-derived outputs; reset forces the idle view and holds fir_clr.
    always_comb begin
        busy    = (r_state != ST_IDLE) && !reset;
        done    = (r_state == ST_DONE) && !reset;
        fir_clr = (r_state == ST_CLEAR) || reset;
        wr_drop = wr_en && busy;
        w_wr_ok = wr_en && (r_state == ST_IDLE) && !reset;
        w_feed  = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    end

    // Read pointer, pass length, phase counter and valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_len_last <= '0;
            r_cnt      <= '0;
            r_vpipe    <= '0;
            r_din_live <= 1'b0;
        end else begin
            r_vpipe    <= {r_vpipe[FIR_LAT-1:0], w_feed};
            r_din_live <= (r_state == ST_RUN);
            if (r_state == ST_CLEAR) begin
                r_rd_ptr   <= '0;
                r_len_last <= c_AW'(calc_len_eff(int'(len), DEPTH) - 1);
            end else if (r_state == ST_RUN) begin
                r_rd_ptr <= w_pass_last ? '0 : r_rd_ptr + c_AW'(1);
            end
            if ((w_state_next == r_state) &&
                ((r_state == ST_FLUSH) || (r_state == ST_DRAIN))) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // The RAM read register doubles as the fir_din register; outside RUN
    // the filter is fed zeros.
    assign fir_din   = (r_din_live && !reset) ? w_ram_q : '0;
    assign out_valid = r_vpipe[FIR_LAT] && !reset;
    assign out_data  = fir_dout;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_stream_ctrl
// Description : Self-checking bench for fir_stream_ctrl: schedule-based
//               reference model checked every cycle, directed scenarios
//               pinned with literal expectations, then randomized runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_stream_ctrl;

    localparam int N       = 16;
    localparam int DEPTH   = 32;
    localparam int FIR_LAT = 2;
    localparam int TAIL    = 3;
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic          wr_drop;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [LW-1:0] len = '0;
    logic          fir_clr;
    logic [N-1:0]  fir_din;
    logic [N-1:0]  fir_dout = '0;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fir_stream_ctrl #(
        .N(N), .DEPTH(DEPTH), .FIR_LAT(FIR_LAT), .TAIL(TAIL)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_drop(wr_drop), .start(start), .stop(stop),
        .loop_en(loop_en), .len(len), .fir_clr(fir_clr), .fir_din(fir_din),
        .fir_dout(fir_dout), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is a timeline: t=0 clear, t=1..S samples read, then TAIL zeros,
    // FIR_LAT drain cycles and the done cycle. S is fixed once the run ends.
    logic [N-1:0] m_mem [DEPTH];
    bit           m_active = 1'b0;
    int           m_t = 0;
    int           m_S = -1;
    int           m_len = DEPTH;

    // per-run observation log for the directed scenarios
    int           cyc = 0;
    int           cnt_ov, cnt_done, cnt_clr, first_ov, first_din;
    logic [N-1:0] din_log [$];

    initial begin
        forever begin : monitor
            logic         e_clr, e_busy, e_done, e_ov, e_drop;
            logic [N-1:0] e_din;
            int           u;
            @(negedge clk);
            cyc++;
            e_clr  = reset || (m_active && m_t == 0);
            e_busy = !reset && m_active;
            e_done = e_busy && m_S >= 0 && m_t == m_S + TAIL + FIR_LAT + 1;
            e_din  = '0;
            if (e_busy && m_t >= 2 && (m_S < 0 || m_t - 1 <= m_S))
                e_din = m_mem[(m_t - 2) % m_len];
            u      = m_t - FIR_LAT;
            e_ov   = e_busy && u >= 2 && (m_S < 0 || u <= m_S + TAIL + 1);
            e_drop = wr_en && e_busy;
            chk("fir_clr",  32'(fir_clr),   32'(e_clr));
            chk("busy",     32'(busy),      32'(e_busy));
            chk("done",     32'(done),      32'(e_done));
            chk("fir_din",  32'(fir_din),   32'(e_din));
            chk("out_valid",32'(out_valid), 32'(e_ov));
            chk("wr_drop",  32'(wr_drop),   32'(e_drop));
            chk("out_data", 32'(out_data),  32'(fir_dout));

            if (busy) din_log.push_back(fir_din);
            if (busy && fir_din != '0 && first_din < 0) first_din = cyc;
            if (out_valid) begin
                cnt_ov++;
                if (first_ov < 0) first_ov = cyc;
            end
            if (done) cnt_done++;
            if (fir_clr && !reset) cnt_clr++;

            // advance the model with the inputs the DUT samples next edge
            if (reset) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (wr_en) m_mem[wr_addr] = wr_data;
                if (start) begin
                    m_active = 1'b1;
                    m_t      = 0;
                    m_S      = -1;
                    m_len    = (len == 0 || int'(len) > DEPTH) ? DEPTH : int'(len);
                end
            end else begin
                if (m_t >= 1 && m_S < 0 && (stop || (m_t % m_len == 0 && !loop_en)))
                    m_S = m_t;
                if (m_S >= 0 && m_t == m_S + TAIL + FIR_LAT + 1) m_active = 1'b0;
                else m_t++;
            end
        end
    end

    // filter output is arbitrary data that must pass straight through
    initial begin
        forever begin
            @(posedge clk);
            #1 fir_dout = N'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        cnt_ov = 0; cnt_done = 0; cnt_clr = 0;
        first_ov = -1; first_din = -1;
        din_log.delete();
    endtask

    task automatic start_run(input int l, input bit lp);
        len = LW'(l); loop_en = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        if (busy) begin
            n_chk++; n_err++;
            $display("FAIL %s: busy still 1 after 400 cycles, expected 0", name);
        end
    endtask

    // Mismatches of the logged stream against nsamp samples (j%modulo)+1
    // followed by TAIL zeros, starting at the first nonzero entry.
    function automatic int seq_errs(input int nsamp, input int modulo);
        int p = -1;
        int bad = 0;
        for (int i = 0; i < din_log.size(); i++)
            if (p < 0 && din_log[i] != '0) p = i;
        if (p < 0 || p + nsamp + TAIL > din_log.size()) return 999;
        for (int j = 0; j < nsamp + TAIL; j++) begin
            if (din_log[p + j] !== ((j < nsamp) ? N'((j % modulo) + 1) : N'(0))) bad++;
        end
        return bad;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        clear_log();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_fir_clr",   32'(fir_clr),   32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fir_din",   32'(fir_din),   32'd0);
        chk("rst_done",      32'(done),      32'd0);
        reset = 1'b0;

        // full buffer of 1..32, len=0
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = N'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        clear_log();
        start_run(0, 1'b0);
        wait_idle("t1_wait");
        chk("t1_clr_count",  32'(cnt_clr),  32'd1);
        chk("t1_ov_count",   32'(cnt_ov),   32'd35);
        chk("t1_done_count", 32'(cnt_done), 32'd1);
        chk("t1_ov_latency", 32'(first_ov - first_din), 32'd2);
        chk("t1_din_seq",    32'(seq_errs(32, 32)), 32'd0);

        // loop of 5, stop on the 12th sample
        clear_log();
        start_run(5, 1'b1);
        repeat (12) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0; loop_en = 1'b0;
        wait_idle("t2_wait");
        chk("t2_din_seq",    32'(seq_errs(12, 5)), 32'd0);
        chk("t2_ov_count",   32'(cnt_ov),   32'd15);
        chk("t2_done_count", 32'(cnt_done), 32'd1);

        // write during RUN is dropped
        clear_log();
        start_run(0, 1'b0);
        repeat (2) tick();
        wr_en = 1'b1; wr_addr = '0; wr_data = 16'hDEAD;
        #1 chk("t3_wr_drop", 32'(wr_drop), 32'd1);
        tick();
        wr_en = 1'b0;
        wait_idle("t3_wait");
        clear_log();
        start_run(1, 1'b0);
        wait_idle("t3b_wait");
        chk("t3_buf0_kept", 32'(seq_errs(1, 1)), 32'd0);
        chk("t3_ov_count",  32'(cnt_ov), 32'd4);

        // start while busy is ignored
        clear_log();
        start_run(8, 1'b0);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t4_wait");
        chk("t4_clr_count", 32'(cnt_clr), 32'd1);
        chk("t4_ov_count",  32'(cnt_ov),  32'd11);
        chk("t4_done",      32'(cnt_done), 32'd1);

        // reset during FLUSH aborts without done
        clear_log();
        start_run(4, 1'b0);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_busy",      32'(busy),      32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        repeat (4) tick();
        chk("t5_no_done",   32'(cnt_done),  32'd0);
        clear_log();
        start_run(0, 1'b0);
        wait_idle("t5b_wait");
        chk("t5_rerun_ov",   32'(cnt_ov),   32'd35);
        chk("t5_rerun_done", 32'(cnt_done), 32'd1);

        // oversize length clamps to DEPTH
        clear_log();
        start_run(40, 1'b0);
        wait_idle("t6_wait");
        chk("t6_ov_count", 32'(cnt_ov), 32'd35);
        chk("t6_done",     32'(cnt_done), 32'd1);

        // randomized runs, checked every cycle by the model
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 3)) begin
                wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = N'($urandom);
                tick();
            end
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom); wr_data = N'($urandom);
            len     = LW'($urandom_range(0, 40));
            loop_en = ($urandom_range(0, 2) == 0);
            start   = 1'b1;
            tick();
            start = 1'b0; wr_en = 1'b0;
            for (int k = 0; k < 150 && busy; k++) begin
                stop    = ($urandom_range(0, 19) == 0) || (k >= 100);
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_addr = AW'($urandom); wr_data = N'($urandom);
                start   = ($urandom_range(0, 7) == 0);
                reset   = ($urandom_range(0, 249) == 0);
                tick();
            end
            stop = 1'b0; start = 1'b0; wr_en = 1'b0; reset = 1'b0; loop_en = 1'b0;
            tick();
            if (busy) begin
                n_chk++; n_err++;
                $display("FAIL rnd_timeout: busy=1 expected 0 after run %0d", r);
            end
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
